// File: rtl/load_store_unit_if.sv
// Request and data-memory signal bundle for the load/store unit.
// No storage: pure wiring between the core, the LSU and the data memory.
// The slave modport is the LSU's view; the master modport is the core/memory view.
`timescale 1ns/1ps
interface load_store_unit_if;
    logic        Req;
    logic        IsStore;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [31:0] LoadData;
    logic [31:0] MemAddr;
    logic [1:0]  MemSize;
    logic [31:0] MemDataIn;
    logic [31:0] MemDataOut;
    logic        MemWEN;

    modport slave (
        input  Req, IsStore, Funct3, Addr, StoreData, MemDataOut,
        output Busy, Done, Err, LoadData, MemAddr, MemSize, MemDataIn, MemWEN
    );

    modport master (
        output Req, IsStore, Funct3, Addr, StoreData, MemDataOut,
        input  Busy, Done, Err, LoadData, MemAddr, MemSize, MemDataIn, MemWEN
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator: funct3 decode, alignment check, lane extraction, extension.
// Latency: Done 1 cycle after acceptance for aligned, N beats for split, same edge for rejects.
// Req is only sampled while idle; requests during Busy are dropped. Split mode: LSU_MISALIGN_SPLIT_EN.
`timescale 1ns/1ps
module load_store_unit (
    input  logic             CLK,
    input  logic             RST,
    load_store_unit_if.slave bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, SPLIT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1} state_t;
`endif

    state_t      state, state_d;
    logic [31:0] addr_q, data_q, ld_q;
    logic [2:0]  f3_q;
    logic        st_q, done_q, err_q;
    logic        done_d, err_d, accept, illegal, misal;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  beat_q;
    logic [31:0] asm_q, asm_next;
    logic        last_beat;
`endif

    // Sign/zero extension of the selected lane; word passes through.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   extend = {{24{raw[7]  & ~f3[2]}}, raw[7:0]};
            2'b01:   extend = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    // Decode of the incoming request: illegal width codes and misalignment.
    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        if (bus.IsStore)
            illegal = bus.Funct3[2] || (bus.Funct3[1:0] == 2'b11);
        else
            illegal = (bus.Funct3[1:0] == 2'b11) || (bus.Funct3 == 3'b110);
        misal = ((bus.Funct3[1:0] == 2'b01) && bus.Addr[0]) ||
                ((bus.Funct3[1:0] == 2'b10) && (bus.Addr[1:0] != 2'b00));
    end

    // Next-state logic and memory-port drive.
    always_comb begin
        state_d       = state;
        done_d        = 1'b0;
        err_d         = 1'b0;
        accept        = 1'b0;
        bus.MemAddr   = 32'd0;
        bus.MemSize   = 2'b10;
        bus.MemDataIn = 32'd0;
        bus.MemWEN    = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
        last_beat = (beat_q == {~f3_q[0], 1'b1});
        asm_next  = asm_q;
        asm_next[{beat_q, 3'b000} +: 8] = bus.MemDataOut[7:0];
`endif
        case (state)
            IDLE: begin
                if (bus.Req) begin
                    accept = 1'b1;
                    if (illegal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (misal) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        state_d = SPLIT;
`else
                        done_d = 1'b1;
                        err_d  = 1'b1;
`endif
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                bus.MemAddr   = addr_q;
                bus.MemSize   = f3_q[1:0];
                bus.MemDataIn = data_q;
                bus.MemWEN    = ~st_q;
                state_d       = IDLE;
                done_d        = 1'b1;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                bus.MemAddr   = addr_q + {30'd0, beat_q};
                bus.MemSize   = 2'b00;
                bus.MemDataIn = {24'd0, 8'(data_q >> {beat_q, 3'b000})};
                bus.MemWEN    = ~st_q;
                if (last_beat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, request latches, completion pulses and load result, all on the falling edge.
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            addr_q <= 32'd0;
            data_q <= 32'd0;
            f3_q   <= 3'd0;
            st_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ld_q   <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            beat_q <= 2'd0;
            asm_q  <= 32'd0;
`endif
        end else begin
            state  <= state_d;
            done_q <= done_d;
            err_q  <= err_d;
            if (accept) begin
                addr_q <= bus.Addr;
                data_q <= bus.StoreData;
                f3_q   <= bus.Funct3;
                st_q   <= bus.IsStore;
            end
            if (state == ACCESS && !st_q)
                ld_q <= extend(bus.MemDataOut, f3_q);
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state == SPLIT) begin
                if (!st_q)
                    asm_q <= asm_next;
                if (last_beat) begin
                    beat_q <= 2'd0;
                    if (!st_q)
                        ld_q <= extend(asm_next, f3_q);
                end else begin
                    beat_q <= beat_q + 2'd1;
                end
            end
`endif
        end
    end

    assign bus.Busy     = (state != IDLE);
    assign bus.Done     = done_q;
    assign bus.Err      = err_q;
    assign bus.LoadData = ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array data memory.
// Expected results come from a byte-level model: loads assemble little-endian bytes and extend.
// Directed cases from the test plan, then randomized requests, then reset mid-access.
`timescale 1ns/1ps
module tb_load_store_unit;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    load_store_unit_if bus();
    load_store_unit dut (.CLK(CLK), .RST(RST), .bus(bus));

    logic [7:0]  mem     [0:255] = '{default: 8'h00};
    logic [7:0]  exp_mem [0:255] = '{default: 8'h00};
    logic [31:0] exp_ld = 32'd0;
    int total = 0;
    int bad   = 0;

    // Data memory: combinational read with lanes replicated
    logic [7:0] ma;
    always_comb begin
        ma = bus.MemAddr[7:0];
        case (bus.MemSize)
            2'b00:   bus.MemDataOut = {4{mem[ma]}};
            2'b01:   bus.MemDataOut = {2{mem[ma + 8'd1], mem[ma]}};
            default: bus.MemDataOut = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
        endcase
    end

    // Data memory: write commits at the falling edge ending the driving cycle
    always @(negedge CLK) begin
        if (RST && !bus.MemWEN) begin
            mem[ma] <= bus.MemDataIn[7:0];
            if (bus.MemSize != 2'b00) mem[ma + 8'd1] <= bus.MemDataIn[15:8];
            if (bus.MemSize == 2'b10) begin
                mem[ma + 8'd2] <= bus.MemDataIn[23:16];
                mem[ma + 8'd3] <= bus.MemDataIn[31:24];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] dut_word(input logic [31:0] a);
        dut_word = {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[8'(a)]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        ref_word = {exp_mem[8'(a + 3)], exp_mem[8'(a + 2)], exp_mem[8'(a + 1)], exp_mem[8'(a)]};
    endfunction

    // Issue one request (caller sits just after a rising edge) and check its outcome.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        bit ill, mis, rej, seen;
        int n, exp_lat, exp_wen, lat, wen;
        logic [31:0] v;
        n   = 1 << f3[1:0];
        ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        mis = !ill && ((a % n) != 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        rej = ill;
`else
        rej = ill || mis;
`endif
        exp_lat = rej ? 0 : (mis ? n : 1);
        exp_wen = (st && !rej) ? exp_lat : 0;
        if (!rej && !st) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v |= 32'(exp_mem[8'(a + i)]) << (8 * i);
            if (f3 inside {3'd0, 3'd1} && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
            exp_ld = v;
        end
        if (!rej && st)
            for (int i = 0; i < n; i++) exp_mem[8'(a + i)] = 8'(d >> (8 * i));

        bus.Req = 1'b1; bus.IsStore = st; bus.Funct3 = f3; bus.Addr = a; bus.StoreData = d;
        @(negedge CLK);
        @(posedge CLK); #1;
        if (!hold) bus.Req = 1'b0;
        chk("busy_after_accept", {31'd0, bus.Busy}, {31'd0, exp_lat != 0});
        lat = 0; wen = 0; seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.Done) begin
                seen = 1;
                break;
            end
            if (!bus.MemWEN) wen++;
            lat++;
            @(posedge CLK); #1;
        end
        bus.Req = 1'b0;
        if (!seen) lat = -1;
        chk("done_latency", lat, exp_lat);
        chk("err", {31'd0, bus.Err}, {31'd0, rej});
        chk("load_data", bus.LoadData, exp_ld);
        chk("wen_low_cycles", wen, exp_wen);
        chk("mem_bytes", dut_word(a), ref_word(a));
        if (hold) begin
            wen = 0; lat = 0;
            for (int c = 0; c < 3; c++) begin
                @(posedge CLK); #1;
                if (!bus.MemWEN) wen++;
                if (bus.Done || bus.Busy) lat++;
            end
            chk("hold_no_second_access", wen + lat, 0);
        end
    endtask

    initial begin
        RST = 1'b0;
        bus.Req = 1'b0; bus.IsStore = 1'b0; bus.Funct3 = 3'd0; bus.Addr = 32'd0; bus.StoreData = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_err", {31'd0, bus.Err}, 32'd0);
        chk("rst_loaddata", bus.LoadData, 32'd0);
        chk("rst_wen", {31'd0, bus.MemWEN}, 32'd1);
        chk("rst_memaddr", bus.MemAddr, 32'd0);
        chk("rst_memsize", {30'd0, bus.MemSize}, 32'd2);
        chk("rst_memdatain", bus.MemDataIn, 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Preload 0x10..0x13 = 84 83 82 81 and 0x14 = 5A through the unit
        run_op(1'b1, 3'b010, 32'h10, 32'h8182_8384, 0);
        run_op(1'b1, 3'b000, 32'h14, 32'h0000_005A, 0);

        run_op(1'b0, 3'b010, 32'h10, 32'd0, 0);
        chk("lw_0x10", bus.LoadData, 32'h8182_8384);
        run_op(1'b0, 3'b000, 32'h13, 32'd0, 0);
        chk("lb_0x13", bus.LoadData, 32'hFFFF_FF81);
        run_op(1'b0, 3'b100, 32'h13, 32'd0, 0);
        chk("lbu_0x13", bus.LoadData, 32'h0000_0081);
        run_op(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 0);
        chk("sh_bytes", {16'd0, mem[8'h23], mem[8'h22]}, 32'h0000_BEEF);
        run_op(1'b0, 3'b101, 32'h22, 32'd0, 0);
        chk("lhu_0x22", bus.LoadData, 32'h0000_BEEF);
        run_op(1'b0, 3'b001, 32'h22, 32'd0, 0);
        chk("lh_0x22", bus.LoadData, 32'hFFFF_BEEF);

        run_op(1'b0, 3'b010, 32'h11, 32'd0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("lw_misaligned_split", bus.LoadData, 32'h5A81_8283);
`else
        chk("lw_misaligned_held", bus.LoadData, 32'hFFFF_BEEF);
`endif
        run_op(1'b0, 3'b011, 32'h10, 32'd0, 0);
        run_op(1'b0, 3'b110, 32'h10, 32'd0, 0);
        run_op(1'b1, 3'b011, 32'h10, 32'd0, 0);
        run_op(1'b1, 3'b000, 32'h50, 32'h0000_0077, 1);
        run_op(1'b0, 3'b010, 32'h10, 32'd0, 1);

        for (int k = 0; k < 150; k++)
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(32'h40, 32'hEF)), $urandom, 0);

        // Reset during a store in flight
        run_op(1'b1, 3'b010, 32'h30, 32'h1122_3344, 0);
        run_op(1'b1, 3'b000, 32'h34, 32'h0000_0055, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        bus.Req = 1'b1; bus.IsStore = 1'b1; bus.Funct3 = 3'b010;
        bus.Addr = 32'h31; bus.StoreData = 32'hAABB_CCDD;
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.Req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0; #1;
        exp_mem[8'h31] = 8'hDD;
        exp_mem[8'h32] = 8'hCC;
`else
        bus.Req = 1'b1; bus.IsStore = 1'b1; bus.Funct3 = 3'b010;
        bus.Addr = 32'h30; bus.StoreData = 32'hAABB_CCDD;
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.Req = 1'b0;
        RST = 1'b0; #1;
`endif
        exp_ld = 32'd0;
        chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.Done}, 32'd0);
        chk("midrst_wen", {31'd0, bus.MemWEN}, 32'd1);
        chk("midrst_loaddata", bus.LoadData, 32'd0);
        @(negedge CLK);
        @(posedge CLK); #1;
        chk("midrst_mem_lo", dut_word(32'h30), ref_word(32'h30));
        chk("midrst_mem_hi", dut_word(32'h34), ref_word(32'h34));
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("midrst_mem_const", dut_word(32'h31), 32'h5511_CCDD);
`else
        chk("midrst_mem_const", dut_word(32'h30), 32'h1122_3344);
`endif
        RST = 1'b1;
        @(posedge CLK); #1;
        run_op(1'b0, 3'b010, 32'h30, 32'd0, 0);
        run_op(1'b0, 3'b100, 32'h34, 32'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
